// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: control sequencer for a time-multiplexed FIR datapath.
// Divides the system clock down to a sample strobe, walks every tap through
// one shared multiplier/accumulator, and shares the coefficient RAM port
// between the tap sequencer and host coefficient writes.
module fir_mac_sequencer #(
  parameter int CLK_DIV  = 20,
  parameter int NUM_TAPS = 16,
  parameter int ADDR_W   = 5,
  parameter int COEF_W   = 16
) (
  input  logic              iClk_12MHz,
  input  logic              iRsn,
  input  logic              iEnable,
  input  logic              iCoefWrReq,
  input  logic [ADDR_W-1:0] iCoefWrAddr,
  input  logic [COEF_W-1:0] iCoefWrData,
  output logic              oCoefWrAck,
  output logic              oEnSample_600kHz,
  output logic [ADDR_W-1:0] oCoefAddr,
  output logic              oCoefRdEn,
  output logic              oCoefWrEn,
  output logic [COEF_W-1:0] oCoefWrData,
  output logic [ADDR_W-1:0] oTapSel,
  output logic              oAccClr,
  output logic              oAccEn,
  output logic              oFirValid,
  output logic              oBusy,
  output logic              oOverrun
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_TAP  = ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W:0]   TAP_LIMIT = (ADDR_W + 1)'(NUM_TAPS);

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, DONE} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  sampleCnt_q;
  logic [CNT_W-1:0]  sampleCnt_d;
  logic              strobe_q;
  logic              strobe_d;
  logic [ADDR_W-1:0] tapIdx_q;
  logic [ADDR_W-1:0] tapNext;
  logic              wrInRange;

  logic              coefWrAck_q;
  logic [ADDR_W-1:0] coefAddr_q;
  logic              coefRdEn_q;
  logic              coefWrEn_q;
  logic [COEF_W-1:0] coefWrData_q;
  logic [ADDR_W-1:0] tapSel_q;
  logic              accClr_q;
  logic              accEn_q;
  logic              firValid_q;
  logic              busy_q;
  logic              overrun_q;

  assign tapNext   = tapIdx_q + ADDR_W'(1);
  assign wrInRange = ({1'b0, iCoefWrAddr} < TAP_LIMIT);

  // Next divider count and strobe: disabling parks the count at zero so the first strobe after enable is a full period away
  always_comb begin
    sampleCnt_d = '0;
    strobe_d    = 1'b0;
    if (iEnable) begin
      strobe_d    = (sampleCnt_q == CNT_MAX);
      sampleCnt_d = strobe_d ? '0 : sampleCnt_q + CNT_W'(1);
    end
  end

  // Divider count and registered sample strobe
  always_ff @(posedge iClk_12MHz or negedge iRsn) begin
    if (!iRsn) begin
      sampleCnt_q <= '0;
      strobe_q    <= 1'b0;
    end else begin
      sampleCnt_q <= sampleCnt_d;
      strobe_q    <= strobe_d;
    end
  end

  // Tap sequencer, RAM port arbitration and all registered control outputs; a strobe wins the idle port over a host write
  always_ff @(posedge iClk_12MHz or negedge iRsn) begin
    if (!iRsn) begin
      state_q      <= IDLE;
      tapIdx_q     <= '0;
      coefWrAck_q  <= 1'b0;
      coefAddr_q   <= '0;
      coefRdEn_q   <= 1'b0;
      coefWrEn_q   <= 1'b0;
      coefWrData_q <= '0;
      tapSel_q     <= '0;
      accClr_q     <= 1'b0;
      accEn_q      <= 1'b0;
      firValid_q   <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      coefWrAck_q  <= 1'b0;
      coefAddr_q   <= '0;
      coefRdEn_q   <= 1'b0;
      coefWrEn_q   <= 1'b0;
      coefWrData_q <= '0;
      tapSel_q     <= '0;
      accClr_q     <= 1'b0;
      accEn_q      <= 1'b0;
      firValid_q   <= 1'b0;
      if (strobe_q && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (strobe_q) begin
            state_q    <= MAC;
            tapIdx_q   <= '0;
            coefRdEn_q <= 1'b1;
            coefAddr_q <= '0;
            busy_q     <= 1'b1;
          end else if (iCoefWrReq && !coefWrAck_q) begin
            coefWrAck_q  <= 1'b1;
            coefWrEn_q   <= wrInRange;
            coefAddr_q   <= iCoefWrAddr;
            coefWrData_q <= iCoefWrData;
          end
        end
        MAC: begin
          accEn_q  <= 1'b1;
          accClr_q <= (tapIdx_q == '0);
          tapSel_q <= tapIdx_q;
          if (tapIdx_q == LAST_TAP) begin
            state_q <= DRAIN;
          end else begin
            tapIdx_q   <= tapNext;
            coefRdEn_q <= 1'b1;
            coefAddr_q <= tapNext;
          end
        end
        DRAIN: begin
          state_q    <= DONE;
          firValid_q <= 1'b1;
        end
        DONE: begin
          state_q  <= IDLE;
          tapIdx_q <= '0;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign oCoefWrAck       = coefWrAck_q;
  assign oEnSample_600kHz = strobe_q;
  assign oCoefAddr        = coefAddr_q;
  assign oCoefRdEn        = coefRdEn_q;
  assign oCoefWrEn        = coefWrEn_q;
  assign oCoefWrData      = coefWrData_q;
  assign oTapSel          = tapSel_q;
  assign oAccClr          = accClr_q;
  assign oAccEn           = accEn_q;
  assign oFirValid        = firValid_q;
  assign oBusy            = busy_q;
  assign oOverrun         = overrun_q;

endmodule
